// File: rtl/challenge_poly_stream.sv
// Streams the challenge polynomial c out of BRAM one coefficient at a time, mapping {0,+1,-1}
// into [0,Q) and checking that exactly TAU coefficients are nonzero.
module challenge_poly_stream #(
  parameter int unsigned N               = 256,
  parameter int unsigned COEFF_WIDTH     = 24,
  parameter int unsigned WORD_LEN        = 96,
  parameter int unsigned ADDR_POLY_WIDTH = 7,
  parameter int unsigned TAU             = 60,
  parameter int unsigned Q               = 8380417
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [ADDR_POLY_WIDTH-1:0] addr_poly_c,
  input  logic [WORD_LEN-1:0]        dout_poly_c,
  output logic [COEFF_WIDTH-1:0]     coeff_out,
  output logic                       coeff_valid,
  input  logic                       coeff_ready,
  output logic [7:0]                 coeff_idx,
  output logic                       coeff_last,
  output logic                       done,
  output logic                       weight_err
);

  localparam int unsigned CoeffPerWord = WORD_LEN / COEFF_WIDTH;
  localparam int unsigned LaneW        = $clog2(CoeffPerWord);
  localparam int unsigned LastWord     = N / CoeffPerWord - 1;
  localparam int unsigned LastLane     = CoeffPerWord - 1;

  localparam logic [COEFF_WIDTH-1:0] CoeffZero   = '0;
  localparam logic [COEFF_WIDTH-1:0] CoeffPlus   = COEFF_WIDTH'(1);
  localparam logic [COEFF_WIDTH-1:0] CoeffMinus  = '1;
  localparam logic [COEFF_WIDTH-1:0] CoeffQMinus = COEFF_WIDTH'(Q - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StEmit, StFinish} state_e;

  state_e                     state_q;
  logic [ADDR_POLY_WIDTH-1:0] word_ptr_q;
  logic [LaneW-1:0]           lane_q;
  logic [WORD_LEN-1:0]        word_q;
  logic [8:0]                 weight_q;
  logic                       illegal_q;
  logic                       weight_err_q;

  logic [COEFF_WIDTH-1:0] lanes [CoeffPerWord];
  logic [COEFF_WIDTH-1:0] lane_coeff;
  logic [COEFF_WIDTH-1:0] mapped;
  logic                   is_zero, is_pos, is_neg;
  logic                   emit, xfer, at_last_lane, at_last_word;
  logic [8:0]             weight_nxt;
  logic                   illegal_nxt;

  for (genvar j = 0; j < CoeffPerWord; j++) begin : g_lane
    assign lanes[j] = word_q[j*COEFF_WIDTH +: COEFF_WIDTH];
  end

  always_comb begin
    lane_coeff   = lanes[lane_q];
    is_zero      = (lane_coeff == CoeffZero);
    is_pos       = (lane_coeff == CoeffPlus);
    is_neg       = (lane_coeff == CoeffMinus);
    mapped       = is_pos ? CoeffPlus : (is_neg ? CoeffQMinus : CoeffZero);
    emit         = (state_q == StEmit);
    xfer         = emit && coeff_ready;
    at_last_lane = (lane_q == LaneW'(LastLane));
    at_last_word = (word_ptr_q == ADDR_POLY_WIDTH'(LastWord));
    weight_nxt   = weight_q + {8'd0, is_pos | is_neg};
    illegal_nxt  = illegal_q | ~(is_zero | is_pos | is_neg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      word_ptr_q   <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      weight_q     <= '0;
      illegal_q    <= 1'b0;
      weight_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StFetch;
            word_ptr_q   <= '0;
            lane_q       <= '0;
            weight_q     <= '0;
            illegal_q    <= 1'b0;
            weight_err_q <= 1'b0;
          end
        end
        StFetch: state_q <= StLatch;
        StLatch: begin
          word_q  <= dout_poly_c;
          lane_q  <= '0;
          state_q <= StEmit;
        end
        StEmit: begin
          if (xfer) begin
            weight_q  <= weight_nxt;
            illegal_q <= illegal_nxt;
            if (!at_last_lane) begin
              lane_q <= lane_q + LaneW'(1);
            end else if (!at_last_word) begin
              word_ptr_q <= word_ptr_q + ADDR_POLY_WIDTH'(1);
              state_q    <= StFetch;
            end else begin
              // Fold in the final coefficient so the verdict is ready alongside done.
              weight_err_q <= illegal_nxt || (weight_nxt != 9'(TAU));
              state_q      <= StFinish;
            end
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign addr_poly_c = word_ptr_q;
  assign coeff_valid = emit;
  assign coeff_out   = emit ? mapped : '0;
  assign coeff_idx   = emit ? 8'(int'(word_ptr_q) * int'(CoeffPerWord) + int'(lane_q)) : 8'd0;
  assign coeff_last  = emit && at_last_lane && at_last_word;
  assign done        = (state_q == StFinish);
  assign weight_err  = weight_err_q;

endmodule

// File: doc/challenge_poly_stream.md
CHALLENGE_POLY_STREAM -- requirements
Module: challenge_poly_stream

Interface
REQ-001 Parameter N, default 256, coefficients per polynomial.
REQ-002 Parameter COEFF_WIDTH, default 24, stored signed coefficient width and coeff_out width.
REQ-003 Parameter WORD_LEN, default 96, BRAM word width; COEFF_PER_WORD = WORD_LEN/COEFF_WIDTH = 4.
REQ-004 Parameter ADDR_POLY_WIDTH, default 7, BRAM address width.
REQ-005 Parameter TAU, default 60, required count of nonzero coefficients.
REQ-006 Parameter Q, default 8380417, modulus.
REQ-007 Port: clk, input, 1, single clock, all logic on rising edge.
REQ-008 Port: rst, input, 1, asynchronous active-high reset.
REQ-009 Port: start, input, 1, single-cycle request to stream challenge polynomial c.
REQ-010 Port: addr_poly_c, output, ADDR_POLY_WIDTH, read address to c BRAM.
REQ-011 Port: dout_poly_c, input, WORD_LEN, BRAM read data, valid one cycle after address.
REQ-012 Port: coeff_out, output, COEFF_WIDTH, coefficient in [0,Q).
REQ-013 Port: coeff_valid / coeff_ready, output / input, 1 each, stream handshake.
REQ-014 Port: coeff_idx, output, 8, index of coeff_out (0..N-1).
REQ-015 Port: coeff_last, output, 1, high with coeff_idx = N-1.
REQ-016 Port: done, output, 1, one-cycle pulse at stream end.
REQ-017 Port: weight_err, output, 1, high if weight != TAU or illegal coefficient seen.

Function
REQ-018 States IDLE, FETCH, LATCH, EMIT, FINISH; no other states reachable.
REQ-019 IDLE: start=1 at edge k -> FETCH, word pointer=0, weight counter=0, weight_err cleared.
REQ-020 FETCH: addr_poly_c=word pointer; next edge -> LATCH.
REQ-021 LATCH: at edge, dout_poly_c captured into word register, lane=0; -> EMIT; first coeff_valid high after edge k+2.
REQ-022 EMIT: coeff_valid=1; lane j presents bits [j*24 +: 24]; coeff_idx = 4*word + j.
REQ-023 Transfer occurs only on edge with coeff_valid && coeff_ready; lane increments per transfer.
REQ-024 While coeff_valid && !coeff_ready, coeff_out, coeff_idx, coeff_last held stable.
REQ-025 Transfer of lane 3 with word < N/4-1 -> FETCH, word+1 (2-cycle bubble per word).
REQ-026 Transfer of lane 3 with word = N/4-1 -> FINISH; addresses never exceed N/4-1.
REQ-027 Mapping: stored 0 -> 0; +1 -> 1; -1 (all ones) -> Q-1 = 8380416.
REQ-028 Any other stored value -> coeff_out 0, sticky illegal flag set.
REQ-029 Weight counter increments on each transferred coefficient mapped from +1 or -1; width 9 bits, no wrap for N=256.
REQ-030 FINISH: done=1 for exactly one cycle; weight_err = illegal || (weight != TAU), registered same edge; -> IDLE.
REQ-031 weight_err holds from FINISH until next accepted start.
REQ-032 start ignored in all states except IDLE; start in FINISH cycle ignored.
REQ-033 coeff_valid=0 in IDLE, FETCH, LATCH, FINISH.

Reset
REQ-034 rst=1 asynchronously forces IDLE, clears word pointer, lane, counters, word register.
REQ-035 Reset values: addr_poly_c=0, coeff_out=0, coeff_valid=0, coeff_idx=0, coeff_last=0, done=0, weight_err=0.
REQ-036 Reset mid-stream abandons transfer; no done pulse; next start restarts at coefficient 0.

Verification
REQ-037 Hold rst 5 cycles -> all outputs 0; no activity without start.
REQ-038 BRAM preloaded: coeffs 0..59 alternating +1/-1, rest 0; start, coeff_ready=1 -> 256 transfers, idx 0..255, values 1,8380416,...,0, coeff_last at idx 255, single done, weight_err=0, first valid 2 edges after start.
REQ-039 Same image, coeff_ready random 50% -> identical sequence, no drops/duplicates, outputs stable while stalled.
REQ-040 Image with 59 nonzero coefficients -> done, weight_err=1; image with 61 -> weight_err=1.
REQ-041 Coefficient 17 stored as 2, weight 60 otherwise -> idx 17 outputs 0, weight_err=1.
REQ-042 rst asserted after idx 100 transfer -> outputs 0 same cycle, no done; second start mid-stream ignored; restart yields full correct stream.
